// File: rtl/bcd_pkg.sv
// Shared types and constants for the four-digit BCD down timer.
// Holds the FSM state encoding, digit geometry and a BCD validity helper.
package bcd_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // True when every packed digit of v is a legal decimal digit.
  function automatic logic is_valid_bcd(input logic [DIGIT_W*NUM_DIGITS-1:0] v);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[i*DIGIT_W +: DIGIT_W] > BCD_MAX) return 1'b0;
    end
    return 1'b1;
  endfunction

endpackage

// File: rtl/cnt10_down.sv
// One BCD digit: parallel load or decrement-with-wrap (0 -> 9).
// Load wins over decrement; synchronous active-low reset clears the digit.
module cnt10_down
  import bcd_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [DIGIT_W-1:0] d,
  input  logic               dec,
  output logic [DIGIT_W-1:0] q
);

  logic [DIGIT_W-1:0] q_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q <= '0;
    end else if (load) begin
      q_q <= d;
    end else if (dec) begin
      q_q <= (q_q == '0) ? BCD_MAX : q_q - DIGIT_W'(1);
    end
  end

  assign q = q_q;

endmodule

// File: rtl/bcd_down_timer.sv
// Four-digit BCD down timer with load/start/pause control and optional
// auto-reload on expiry. Digits are cnt10_down instances chained via brw.
module bcd_down_timer
  import bcd_pkg::*;
#(
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        start,
  input  logic        pause,
  output logic [15:0] q,
  output logic [3:1]  brw,
  output logic        running,
  output logic        done,
  output logic        done_p,
  output logic        err
);

  state_e      state_q;
  logic [15:0] reload_q;
  logic        done_p_q;
  logic        err_q;

  logic        load_ok;
  logic        count_en;
  logic        expire;
  logic        reload_en;
  logic        dig_load;
  logic [15:0] dig_d;
  logic [NUM_DIGITS-1:0] dec;

  assign load_ok   = load && is_valid_bcd(load_val);
  assign count_en  = (state_q == ST_RUN) && (q != '0);
  assign expire    = (state_q == ST_RUN) && (q == '0);
  assign reload_en = expire && AUTO_RELOAD && (reload_q != '0);

  // A valid load beats an expiry reload; an invalid load freezes the digits.
  assign dig_load = load_ok || (!load && reload_en);
  assign dig_d    = load_ok ? load_val : reload_q;

  // NOTE: every output of an always_comb gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    brw    = '0;
    brw[1] = count_en && (q[3:0]  == '0);
    brw[2] = count_en && (q[7:0]  == '0);
    brw[3] = count_en && (q[11:0] == '0);
  end

  assign dec[0] = count_en && !load;
  for (genvar i = 1; i < NUM_DIGITS; i++) begin : g_dec
    assign dec[i] = brw[i] && !load;
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    cnt10_down u_digit (
      .clk   (clk),
      .reset (reset),
      .load  (dig_load),
      .d     (dig_d[i*DIGIT_W +: DIGIT_W]),
      .dec   (dec[i]),
      .q     (q[i*DIGIT_W +: DIGIT_W])
    );
  end

  // Control FSM: reset > load > expiry > pause > start.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      reload_q <= '0;
      done_p_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_p_q <= 1'b0;
      err_q    <= 1'b0;
      if (load) begin
        if (load_ok) begin
          state_q  <= ST_IDLE;
          reload_q <= load_val;
        end else begin
          err_q <= 1'b1;
        end
      end else if (expire) begin
        done_p_q <= 1'b1;
        if (!reload_en) state_q <= ST_DONE;
      end else if (pause) begin
        if (state_q == ST_RUN) state_q <= ST_PAUSE;
      end else if (start && (q != '0) &&
                   ((state_q == ST_IDLE) || (state_q == ST_PAUSE))) begin
        state_q <= ST_RUN;
      end
    end
  end

  assign running = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);
  assign done_p  = done_p_q;
  assign err     = err_q;

endmodule
